// File: rtl/spi_pixel_bridge.sv
// SPI slave bridge: SPI words in/out of the Sobel pixel stream through RX and TX FIFOs.
// Define SPI_BRIDGE_ERR_FLAGS_EN to build the sticky rx_overflow_o / tx_underrun_o flags.
module spi_pixel_bridge #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              spi_sck_i,
  input  logic              spi_cs_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              rx_overflow_o,
  output logic              tx_underrun_o,
  input  logic              err_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   LVL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic          SCK_IDLE  = (CPOL != 0);
  localparam logic          SAMPLE_TR = (CPHA != 0);

  // state | meaning
  // IDLE  | CS high (or not yet seen high since reset); SDO held 0
  // LOAD  | one cycle: pop TX FIFO into the TX shift register
  // SHIFT | sample/shift bits on SCK edges until DATA_W samples
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [1:0] sck_sync_q, cs_sync_q, sdi_sync_q, sync_vld_q;
  logic       sck_prev_q, armed_q;
  logic       sck_s, cs_s, sdi_s;
  logic       sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;

  assign sck_s = sck_sync_q[1];
  assign cs_s  = cs_sync_q[1];
  assign sdi_s = sdi_sync_q[1];

  // armed_q blocks a frame that was already in progress when reset released
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sck_sync_q <= {2{SCK_IDLE}};
      cs_sync_q  <= 2'b11;
      sdi_sync_q <= 2'b00;
      sck_prev_q <= SCK_IDLE;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], spi_sck_i};
      cs_sync_q  <= {cs_sync_q[0], spi_cs_i};
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
      sck_prev_q <= sck_s;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && cs_s) armed_q <= 1'b1;
    end
  end

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
  assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
  assign sample_edge = SAMPLE_TR ? trail_edge : lead_edge;
  assign shift_edge  = SAMPLE_TR ? lead_edge : trail_edge;

  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rx_wr_q, rx_rd_q;
  logic [AW:0]       rx_lvl_q;
  logic              rx_push_q, rx_push_d;
  logic [DATA_W-1:0] rx_word_q, rx_word_d;
  logic              rx_pop, rx_full, rx_wr_en;

  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_full    = (rx_lvl_q == LVL_FULL);
  assign rx_wr_en   = rx_push_q & (~rx_full | rx_pop);
  assign rx_valid_o = (rx_lvl_q != '0);
  assign rx_data_o  = rx_valid_o ? rx_mem_q[rx_rd_q] : '0;

  always_ff @(posedge clk_i) begin
    if (rx_wr_en) rx_mem_q[rx_wr_q] <= rx_word_q;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_lvl_q <= '0;
    end else begin
      if (rx_wr_en) rx_wr_q <= rx_wr_q + PTR_ONE;
      if (rx_pop)   rx_rd_q <= rx_rd_q + PTR_ONE;
      case ({rx_wr_en, rx_pop})
        2'b10:   rx_lvl_q <= rx_lvl_q + LVL_ONE;
        2'b01:   rx_lvl_q <= rx_lvl_q - LVL_ONE;
        default: rx_lvl_q <= rx_lvl_q;
      endcase
    end
  end

  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     tx_wr_q, tx_rd_q;
  logic [AW:0]       tx_lvl_q;
  logic              tx_rdy_q, tx_push, tx_pop, tx_empty;
  logic [DATA_W-1:0] load_word;

  assign tx_empty   = (tx_lvl_q == '0);
  assign tx_ready_o = tx_rdy_q & (tx_lvl_q != LVL_FULL);
  assign tx_push    = tx_valid_i & tx_ready_o;
  assign load_word  = tx_empty ? '0 : tx_mem_q[tx_rd_q];

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_lvl_q <= '0;
      tx_rdy_q <= 1'b0;
    end else begin
      tx_rdy_q <= 1'b1;
      if (tx_push) tx_wr_q <= tx_wr_q + PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl_q <= tx_lvl_q + LVL_ONE;
        2'b01:   tx_lvl_q <= tx_lvl_q - LVL_ONE;
        default: tx_lvl_q <= tx_lvl_q;
      endcase
    end
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
  logic              sdo_q, sdo_d;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      sdo_q     <= 1'b0;
      rx_push_q <= 1'b0;
      rx_word_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      sdo_q     <= sdo_d;
      rx_push_q <= rx_push_d;
      rx_word_q <= rx_word_d;
    end
  end

  // CPHA=0 presents the MSB during LOAD; the trailing edge that closes the
  // previous word (counter already 0) must not shift it away.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    sdo_d     = sdo_q;
    rx_push_d = 1'b0;
    rx_word_d = rx_word_q;
    tx_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        sdo_d     = 1'b0;
        if (armed_q && !cs_s) state_d = LOAD;
      end
      LOAD: begin
        tx_pop  = ~tx_empty;
        tx_sr_d = SAMPLE_TR ? load_word : {load_word[DATA_W-2:0], 1'b0};
        if (!SAMPLE_TR) sdo_d = load_word[DATA_W-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sample_edge) begin
          rx_sr_d = {rx_sr_q[DATA_W-2:0], sdi_s};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            rx_push_d = 1'b1;
            rx_word_d = rx_sr_d;
            state_d   = LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
        if (shift_edge && (SAMPLE_TR || (bit_cnt_q != '0))) begin
          sdo_d   = tx_sr_q[DATA_W-1];
          tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
    if (cs_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sdo_d     = 1'b0;
    end
  end

  assign spi_sdo_o = (state_q != IDLE) & sdo_q;

`ifdef SPI_BRIDGE_ERR_FLAGS_EN
  logic ovf_q, und_q, ovf_set, und_set;

  assign ovf_set = rx_push_q & rx_full & ~rx_pop;
  assign und_set = (state_q == LOAD) & tx_empty;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      ovf_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (und_set)        und_q <= 1'b1;
      else if (err_clr_i) und_q <= 1'b0;
    end
  end

  assign rx_overflow_o = ovf_q;
  assign tx_underrun_o = und_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign rx_overflow_o  = 1'b0;
  assign tx_underrun_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_bridge.sv
// Bench for spi_pixel_bridge: one instance per SPI mode, driven by a shared bit-banged master.
module tb_spi_pixel_bridge;

`ifdef SPI_BRIDGE_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam logic [3:0] SCK_IDLE = 4'b1100;
  localparam logic [3:0] SCK_ACT  = 4'b0011;

  logic       clk, nreset, cs, sdi, rx_ready, tx_valid, err_clr;
  logic [7:0] tx_data;
  logic [3:0] sck, sdo, rx_valid, tx_ready, ovf, und;
  logic [7:0] rx_data [4];

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_pixel_bridge #(.DATA_W(8), .FIFO_DEPTH(4), .CPOL(m / 2), .CPHA(m % 2)) dut (
      .clk_i(clk), .nreset_i(nreset), .spi_sck_i(sck[m]), .spi_cs_i(cs), .spi_sdi_i(sdi),
      .spi_sdo_o(sdo[m]), .rx_data_o(rx_data[m]), .rx_valid_o(rx_valid[m]), .rx_ready_i(rx_ready),
      .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready[m]),
      .rx_overflow_o(ovf[m]), .tx_underrun_o(und[m]), .err_clr_i(err_clr));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [7:0] tx_model_q [$];
  logic [7:0] rx_exp_q [$];
  logic       ovf_exp = 1'b0;
  logic       und_exp = 1'b0;
  logic [7:0] mosi_buf [8];
  logic [7:0] miso_last [4];
  logic [7:0] last_rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_model(output logic [7:0] w);
    if (tx_model_q.size() > 0) w = tx_model_q.pop_front();
    else begin
      w = 8'h00;
      und_exp = 1'b1;
    end
  endtask

  task automatic push_tx(input logic [7:0] w);
    for (int i = 0; i < 50 && !(&tx_ready); i++) wait_clk(1);
    if (!(&tx_ready)) chk("tx_ready_wait", {28'd0, tx_ready}, 32'hF);
    tx_data  = w;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
    tx_model_q.push_back(w);
  endtask

  // tail_bits < 8 aborts the last word early; full words are scored against the models
  task automatic spi_xfer(input int nwords, input int tail_bits);
    logic [7:0] cap [4];
    logic [7:0] exp_miso;
    cs  = 1'b0;
    sdi = mosi_buf[0][7];
    wait_clk(16);
    load_model(exp_miso);
    for (int w = 0; w < nwords; w++) begin
      int nb;
      nb = (w == nwords - 1) ? tail_bits : 8;
      for (int m = 0; m < 4; m++) cap[m] = 8'h00;
      for (int b = 7; b > 7 - nb; b--) begin
        sdi = mosi_buf[w][b];
        wait_clk(4);
        for (int m = 0; m < 4; m += 2) cap[m] = {cap[m][6:0], sdo[m]};
        sck = SCK_ACT;
        wait_clk(8);
        for (int m = 1; m < 4; m += 2) cap[m] = {cap[m][6:0], sdo[m]};
        sck = SCK_IDLE;
        wait_clk(4);
      end
      if (nb == 8) begin
        for (int m = 0; m < 4; m++) begin
          chk($sformatf("miso_w%0d_mode%0d", w, m), cap[m], exp_miso);
          miso_last[m] = cap[m];
        end
        if (rx_exp_q.size() == 4) ovf_exp = 1'b1;
        else rx_exp_q.push_back(mosi_buf[w]);
        load_model(exp_miso);
      end
    end
    wait_clk(4);
    cs = 1'b1;
    wait_clk(16);
  endtask

  task automatic drain_rx(input int n);
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 100 && !(&rx_valid); i++) wait_clk(1);
      if (!(&rx_valid)) begin
        chk("rx_valid_wait", {28'd0, rx_valid}, 32'hF);
        return;
      end
      if (rx_exp_q.size() == 0) begin
        chk("rx_unexpected", 32'd1, 32'd0);
        return;
      end
      exp = rx_exp_q.pop_front();
      for (int m = 0; m < 4; m++) chk($sformatf("rx_data_mode%0d", m), rx_data[m], exp);
      last_rx  = rx_data[0];
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic check_flags(input string tag);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("%s_ovf_mode%0d", tag, m), ovf[m], FLAGS & ovf_exp);
      chk($sformatf("%s_und_mode%0d", tag, m), und[m], FLAGS & und_exp);
    end
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    ovf_exp = 1'b0;
    und_exp = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{8'h3C, 8'hA5, 8'h3C, 8'hA5};
    tbl[1] = '{8'h80, 8'h01, 8'h80, 8'h01};
    tbl[2] = '{8'hFF, 8'h80, 8'hFF, 8'h80};
    tbl[3] = '{8'h01, 8'hFF, 8'h01, 8'hFF};
    tbl[4] = '{8'hC3, 8'h5A, 8'hC3, 8'h5A};
    tbl[5] = '{8'h7E, 8'h00, 8'h7E, 8'h00};

    nreset = 1'b0; cs = 1'b1; sck = SCK_IDLE; sdi = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
    wait_clk(3);
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("rst_tx_ready_mode%0d", m), tx_ready[m], 1'b0);
      chk($sformatf("rst_rx_valid_mode%0d", m), rx_valid[m], 1'b0);
      chk($sformatf("rst_rx_data_mode%0d", m), rx_data[m], 8'h00);
      chk($sformatf("rst_sdo_mode%0d", m), sdo[m], 1'b0);
    end
    check_flags("rst");
    nreset = 1'b1;
    wait_clk(4);
    chk("post_rst_tx_ready", {28'd0, tx_ready}, 32'hF);

    // single-word frames; the trailing LOAD of each frame finds TX empty
    for (int v = 0; v < 6; v++) begin
      push_tx(tbl[v].tx);
      mosi_buf[0] = tbl[v].mosi;
      spi_xfer(1, 8);
      for (int m = 0; m < 4; m++) chk($sformatf("tbl%0d_miso_mode%0d", v, m), miso_last[m], tbl[v].exp_miso);
      drain_rx(1);
      chk($sformatf("tbl%0d_rx", v), last_rx, tbl[v].exp_rx);
    end
    check_flags("tbl");
    clear_flags();
    wait_clk(1);
    check_flags("tbl_clr");

    // 3-word burst under one CS
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h80; mosi_buf[2] = 8'hFF;
    spi_xfer(3, 8);
    drain_rx(3);
    clear_flags();

    // RX overflow: five words with consumer stalled, TX full beforehand
    push_tx(8'hA1); push_tx(8'hA2); push_tx(8'hA3); push_tx(8'hA4);
    wait_clk(1);
    chk("tx_full_ready_low", {28'd0, tx_ready}, 32'h0);
    for (int w = 0; w < 5; w++) mosi_buf[w] = 8'(8'h10 * (w + 1));
    spi_xfer(5, 8);
    check_flags("ovf");
    clear_flags();
    wait_clk(1);
    check_flags("ovf_clr");
    drain_rx(4);
    wait_clk(2);
    chk("ovf_drained_valid", {28'd0, rx_valid}, 32'h0);

    // TX underrun on the first word
    mosi_buf[0] = 8'h33;
    spi_xfer(1, 8);
    for (int m = 0; m < 4; m++) chk($sformatf("und_miso_mode%0d", m), miso_last[m], 8'h00);
    check_flags("und");
    drain_rx(1);
    clear_flags();

    // CS released after 5 bits
    push_tx(8'h99);
    mosi_buf[0] = 8'hE7;
    spi_xfer(1, 5);
    chk("abort_no_push", {28'd0, rx_valid}, 32'h0);
    push_tx(8'h42);
    mosi_buf[0] = 8'h5A;
    spi_xfer(1, 8);
    drain_rx(1);
    chk("abort_next_rx", last_rx, 8'h5A);
    clear_flags();

    // reset mid-word with two RX entries queued
    push_tx(8'h21); push_tx(8'h43);
    mosi_buf[0] = 8'h12; mosi_buf[1] = 8'h34;
    spi_xfer(2, 8);
    chk("pre_rst_valid", {28'd0, rx_valid}, 32'hF);
    cs = 1'b0;
    wait_clk(16);
    for (int b = 0; b < 3; b++) begin
      sdi = b[0];
      wait_clk(4); sck = SCK_ACT; wait_clk(8); sck = SCK_IDLE; wait_clk(4);
    end
    nreset = 1'b0;
    #1;
    chk("midrst_valid", {28'd0, rx_valid}, 32'h0);
    chk("midrst_rx_data", rx_data[0], 8'h00);
    tx_model_q.delete();
    rx_exp_q.delete();
    ovf_exp = 1'b0;
    und_exp = 1'b0;
    wait_clk(3);
    nreset = 1'b1;
    for (int b = 0; b < 8; b++) begin
      sdi = ~b[0];
      wait_clk(4); sck = SCK_ACT; wait_clk(8); sck = SCK_IDLE; wait_clk(4);
    end
    cs = 1'b1;
    wait_clk(16);
    chk("midrst_ignored_frame", {28'd0, rx_valid}, 32'h0);
    chk("midrst_sdo_idle", {28'd0, sdo}, 32'h0);
    check_flags("midrst");
    push_tx(8'h6B);
    mosi_buf[0] = 8'hC6;
    spi_xfer(1, 8);
    drain_rx(1);
    chk("midrst_next_rx", last_rx, 8'hC6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
